// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the instruction/data memory bus arbiter.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_REQ,
        ARB_RESP
    } arb_state_t;

    typedef enum logic {
        OWN_I,
        OWN_D
    } arb_owner_t;

    localparam logic [3:0] ARB_FETCH_BE = 4'hF;

    // Saturating increment for the data grant streak counter.
    function automatic logic [3:0] streak_next(input logic [3:0] cur, input logic [3:0] max);
        return (cur >= max) ? max : cur + 4'd1;
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates one memory bus between instruction fetch and load/store, one
// transaction at a time, with data priority, a fetch anti-starvation streak and a response timeout.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int D_STREAK_MAX = 4,
    parameter int TIMEOUT      = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    output logic        i_ready,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [3:0]  d_be,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ready,
    output logic        bus_req,
    output logic        bus_we,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_gnt,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata,
    output logic        busy,
    output logic        err_timeout
);

    localparam logic [3:0] STREAK_MAX   = 4'(D_STREAK_MAX);
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);
    localparam bit         TIMEOUT_EN   = (TIMEOUT != 0);

    arb_state_t state;
    arb_owner_t owner;
    logic [3:0] streak;
    logic [7:0] tcnt;
    logic       discard;

    logic i_elig;
    logic d_elig;
    logic grant_i;
    logic grant_d;
    logic owner_req;
    logic drop_now;
    logic timed_out;

    // A requester whose ready pulses this cycle is still holding its old request, so mask it.
    assign i_elig    = i_req && !i_ready;
    assign d_elig    = d_req && !d_ready;
    assign grant_i   = i_elig && (!d_elig || (streak == STREAK_MAX));
    assign grant_d   = d_elig && !grant_i;
    assign owner_req = (owner == OWN_D) ? d_req : i_req;
    assign drop_now  = discard || !owner_req;
    assign timed_out = TIMEOUT_EN && !bus_rvalid && (tcnt == TIMEOUT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ARB_IDLE;
            owner       <= OWN_I;
            streak      <= '0;
            tcnt        <= '0;
            discard     <= 1'b0;
            i_rdata     <= '0;
            i_ready     <= 1'b0;
            d_rdata     <= '0;
            d_ready     <= 1'b0;
            bus_req     <= 1'b0;
            bus_we      <= 1'b0;
            bus_be      <= '0;
            bus_addr    <= '0;
            bus_wdata   <= '0;
            busy        <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            i_ready <= 1'b0;
            d_ready <= 1'b0;
            case (state)
                ARB_IDLE: begin
                    discard <= 1'b0;
                    tcnt    <= '0;
                    if (grant_d) begin
                        bus_req   <= 1'b1;
                        bus_we    <= d_we;
                        bus_be    <= d_be;
                        bus_addr  <= d_addr;
                        bus_wdata <= d_wdata;
                        owner     <= OWN_D;
                        streak    <= i_req ? streak_next(streak, STREAK_MAX) : 4'd0;
                        state     <= ARB_REQ;
                        busy      <= 1'b1;
                    end else if (grant_i) begin
                        bus_req   <= 1'b1;
                        bus_we    <= 1'b0;
                        bus_be    <= ARB_FETCH_BE;
                        bus_addr  <= i_addr;
                        bus_wdata <= '0;
                        owner     <= OWN_I;
                        streak    <= '0;
                        state     <= ARB_REQ;
                        busy      <= 1'b1;
                    end
                end
                ARB_REQ: begin
                    if (!owner_req) begin
                        discard <= 1'b1;
                    end
                    if (bus_gnt) begin
                        bus_req <= 1'b0;
                        tcnt    <= '0;
                        state   <= ARB_RESP;
                    end
                end
                ARB_RESP: begin
                    if (!owner_req) begin
                        discard <= 1'b1;
                    end
                    // An abandoned transaction still finishes on the bus but is never reported.
                    if (bus_rvalid) begin
                        state <= ARB_IDLE;
                        busy  <= 1'b0;
                        if (!drop_now) begin
                            if (owner == OWN_D) begin
                                d_ready <= 1'b1;
                                if (!bus_we) begin
                                    d_rdata <= bus_rdata;
                                end
                            end else begin
                                i_ready <= 1'b1;
                                i_rdata <= bus_rdata;
                            end
                        end
                    end else if (timed_out) begin
                        state       <= ARB_IDLE;
                        busy        <= 1'b0;
                        err_timeout <= 1'b1;
                        if (!drop_now) begin
                            if (owner == OWN_D) begin
                                d_ready <= 1'b1;
                                if (!bus_we) begin
                                    d_rdata <= '0;
                                end
                            end else begin
                                i_ready <= 1'b1;
                                i_rdata <= '0;
                            end
                        end
                    end else begin
                        tcnt <= tcnt + 8'd1;
                    end
                end
                default: begin
                    state   <= ARB_IDLE;
                    busy    <= 1'b0;
                    bus_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a simple bus responder, per-port scoreboards
// of expected read data and a log of bus addresses in grant order.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_req;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic        i_ready;
    logic        d_req;
    logic        d_we;
    logic [3:0]  d_be;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_ready;
    logic        bus_req;
    logic        bus_we;
    logic [3:0]  bus_be;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_gnt;
    logic        bus_rvalid = 1'b0;
    logic [31:0] bus_rdata = '0;
    logic        busy;
    logic        err_timeout;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int i_pulses = 0;
    int d_pulses = 0;
    logic gnt_en = 1'b1;
    logic rsp_en = 1'b1;
    int stray_req = 0;
    int stray_ack = 0;
    logic pending = 1'b0;
    logic [31:0] pend_addr = '0;
    logic [31:0] bus_log[$];
    logic [31:0] i_exp[$];
    logic [31:0] d_exp[$];
    logic [31:0] i_model;
    logic [31:0] d_model;

    mem_arbiter #(.D_STREAK_MAX(4), .TIMEOUT(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ready(d_ready),
        .bus_req(bus_req), .bus_we(bus_we), .bus_be(bus_be), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid),
        .bus_rdata(bus_rdata), .busy(busy), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    assign bus_gnt = bus_req && gnt_en;

    function automatic logic [31:0] mem_model(input logic [31:0] a);
        if (a == 32'h0000_0100) return 32'h0050_0093;
        return {~a[15:0], a[15:0]};
    endfunction

    // Bus responder: grant immediately, answer one cycle after the grant.
    always @(negedge clk) begin
        if (i_ready) i_pulses = i_pulses + 1;
        if (d_ready) d_pulses = d_pulses + 1;
        bus_rvalid = 1'b0;
        bus_rdata  = '0;
        if (stray_req != stray_ack) begin
            bus_rvalid = 1'b1;
            bus_rdata  = 32'hDEAD_BEEF;
            stray_ack  = stray_req;
        end else if (pending && rsp_en) begin
            bus_rvalid = 1'b1;
            bus_rdata  = mem_model(pend_addr);
        end
        pending = 1'b0;
        if (bus_req && bus_gnt) begin
            pending   = 1'b1;
            pend_addr = bus_addr;
            bus_log.push_back(bus_addr);
        end
    end

    task automatic check_word(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_bus(input string tag, input logic [31:0] exp);
        logic [31:0] obs;
        obs = (bus_log.size() > 0) ? bus_log.pop_front() : 32'hFFFF_FFFF;
        check_word(tag, obs, exp);
    endtask

    task automatic fetch_txn(input logic [31:0] a, input string tag, output int done_cyc);
        logic seen;
        logic [31:0] exp;
        i_req  = 1'b1;
        i_addr = a;
        i_exp.push_back(mem_model(a));
        seen = 1'b0;
        done_cyc = -1;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (i_ready) begin
                seen = 1'b1;
                done_cyc = cyc;
                break;
            end
        end
        exp = i_exp.pop_front();
        check_bit({tag, "_ready"}, seen, 1'b1);
        if (seen) check_word({tag, "_rdata"}, i_rdata, exp);
        i_req = 1'b0;
    endtask

    task automatic data_txn(input logic [31:0] a, input logic we, input logic [3:0] be,
                            input logic [31:0] wd, input logic [31:0] exp_rdata,
                            input string tag, output int done_cyc);
        logic seen;
        logic [31:0] exp;
        d_req   = 1'b1;
        d_we    = we;
        d_be    = be;
        d_addr  = a;
        d_wdata = wd;
        d_exp.push_back(exp_rdata);
        seen = 1'b0;
        done_cyc = -1;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (d_ready) begin
                seen = 1'b1;
                done_cyc = cyc;
                break;
            end
        end
        exp = d_exp.pop_front();
        check_bit({tag, "_ready"}, seen, 1'b1);
        if (seen) check_word({tag, "_rdata"}, d_rdata, exp);
        d_req = 1'b0;
        d_we  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int ic, dc, t0, p;
        logic [31:0] t3_order[6];
        i_req = 0; i_addr = 0; d_req = 0; d_we = 0; d_be = 0; d_addr = 0; d_wdata = 0;
        i_model = '0;
        d_model = '0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_bit("rst_bus_req", bus_req, 1'b0);
        check_bit("rst_busy", busy, 1'b0);
        check_bit("rst_i_ready", i_ready, 1'b0);
        check_bit("rst_d_ready", d_ready, 1'b0);
        check_word("rst_i_rdata", i_rdata, 32'h0);
        check_word("rst_d_rdata", d_rdata, 32'h0);
        check_bit("rst_err", err_timeout, 1'b0);
        check_word("rst_bus_addr", bus_addr, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single fetch with cycle-exact latency
        i_req = 1'b1; i_addr = 32'h100; i_exp.push_back(mem_model(32'h100));
        @(negedge clk);
        check_bit("t1_bus_req", bus_req, 1'b1);
        check_word("t1_bus_addr", bus_addr, 32'h100);
        check_bit("t1_bus_we", bus_we, 1'b0);
        check_word("t1_bus_be", {28'd0, bus_be}, 32'hF);
        check_bit("t1_busy", busy, 1'b1);
        @(negedge clk);
        check_bit("t1_req_drop", bus_req, 1'b0);
        check_bit("t1_busy_resp", busy, 1'b1);
        @(negedge clk);
        check_bit("t1_ready", i_ready, 1'b1);
        check_word("t1_rdata", i_rdata, i_exp.pop_front());
        i_req = 1'b0;
        @(negedge clk);
        check_bit("t1_ready_pulse", i_ready, 1'b0);
        check_word("t1_rdata_hold", i_rdata, 32'h0050_0093);
        check_bit("t1_idle", busy, 1'b0);
        check_bus("t1_bus_log", 32'h100);
        i_model = mem_model(32'h100);

        // Contention: data first, fetch right behind it
        @(negedge clk);
        fork
            fetch_txn(32'h104, "t2_fetch", ic);
            data_txn(32'h2000, 1'b0, 4'hF, 32'h0, mem_model(32'h2000), "t2_load", dc);
        join
        d_model = mem_model(32'h2000);
        i_model = mem_model(32'h104);
        check_word("t2_gap", 32'(ic - dc), 32'd3);
        check_bus("t2_first", 32'h2000);
        check_bus("t2_second", 32'h104);
        check_word("t2_no_dup", 32'(bus_log.size()), 32'd0);

        // Starvation guard: abandoned data requests re-raised while a fetch waits
        @(negedge clk);
        p = d_pulses;
        t3_order = '{32'h2100, 32'h2104, 32'h2108, 32'h210C, 32'h180, 32'h2110};
        fork
            fetch_txn(32'h180, "t3_fetch", ic);
            begin : data_side
                logic seen;
                for (int k = 0; k < 5; k++) begin
                    d_req = 1'b1; d_we = 1'b0; d_be = 4'hF;
                    d_addr = 32'h2100 + 32'(4 * k);
                    seen = 1'b0;
                    for (int n = 0; n < 40; n++) begin
                        @(negedge clk);
                        if (busy && !bus_req && bus_addr == d_addr) begin
                            seen = 1'b1;
                            break;
                        end
                    end
                    check_bit("t3_d_resp", seen, 1'b1);
                    d_req = 1'b0;
                    @(negedge clk);
                end
            end
        join
        i_model = mem_model(32'h180);
        for (int k = 0; k < 6; k++) check_bus("t3_order", t3_order[k]);
        check_word("t3_no_d_ready", 32'(d_pulses - p), 32'd0);
        check_word("t3_d_rdata_kept", d_rdata, d_model);

        // Store
        @(negedge clk);
        fork
            data_txn(32'h3004, 1'b1, 4'b0011, 32'hCAFE_BABE, d_model, "t4_store", dc);
            begin
                @(negedge clk);
                check_bit("t4_bus_we", bus_we, 1'b1);
                check_word("t4_bus_be", {28'd0, bus_be}, 32'h3);
                check_word("t4_bus_wdata", bus_wdata, 32'hCAFE_BABE);
                check_word("t4_bus_addr", bus_addr, 32'h3004);
            end
        join
        check_bus("t4_bus_log", 32'h3004);

        // Fetch abandoned in RESP
        @(negedge clk);
        p = i_pulses;
        i_req = 1'b1; i_addr = 32'h200;
        @(negedge clk);
        check_bit("t5_req", bus_req, 1'b1);
        @(negedge clk);
        check_bit("t5_resp", busy, 1'b1);
        i_req = 1'b0;
        repeat (3) @(negedge clk);
        check_word("t5_no_ready", 32'(i_pulses - p), 32'd0);
        check_word("t5_rdata_kept", i_rdata, i_model);
        check_bit("t5_idle", busy, 1'b0);
        check_bus("t5_bus_done", 32'h200);

        // Timeout with no response
        rsp_en = 1'b0;
        t0 = cyc;
        data_txn(32'h4000, 1'b0, 4'hF, 32'h0, 32'h0, "t5_timeout", dc);
        d_model = 32'h0;
        check_word("t5_timeout_lat", 32'(dc - t0), 32'd10);
        check_bit("t5_err", err_timeout, 1'b1);
        check_bus("t5_to_bus", 32'h4000);
        rsp_en = 1'b1;
        @(negedge clk);
        data_txn(32'h2200, 1'b0, 4'hF, 32'h0, mem_model(32'h2200), "t5_after", dc);
        d_model = mem_model(32'h2200);
        check_bit("t5_err_sticky", err_timeout, 1'b1);
        check_bus("t5_after_bus", 32'h2200);

        // Asynchronous reset while stuck in REQ
        @(negedge clk);
        gnt_en = 1'b0;
        i_req = 1'b1; i_addr = 32'h300;
        @(negedge clk);
        check_bit("t6_in_req", bus_req, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check_bit("t6_bus_req", bus_req, 1'b0);
        check_bit("t6_busy", busy, 1'b0);
        check_word("t6_i_rdata", i_rdata, 32'h0);
        check_word("t6_d_rdata", d_rdata, 32'h0);
        check_bit("t6_err", err_timeout, 1'b0);
        check_word("t6_bus_addr", bus_addr, 32'h0);
        i_req = 1'b0;
        gnt_en = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        p = i_pulses;
        stray_req = stray_req + 1;
        repeat (3) @(negedge clk);
        check_bit("t6_stray_idle", busy, 1'b0);
        check_word("t6_stray_no_ready", 32'(i_pulses - p), 32'd0);
        check_word("t6_stray_rdata", i_rdata, 32'h0);
        check_word("t6_no_bus", 32'(bus_log.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
